// File: rtl/lm_pkg.sv
// ----------------------------------------------------------------------------
// lm_pkg : shared types and constants for the load-multiple sequencer
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package lm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } lm_state_e;

  localparam int         REG_CNT    = 8;
  localparam logic [2:0] PC_IDX     = 3'd7;
  localparam logic [7:0] MASK_ALL   = 8'hFF;
  localparam logic [7:0] MASK_NO_PC = 8'h7F;

endpackage

`default_nettype wire

// File: rtl/load_multiple_sequencer_lowest_set_bit_8.sv
// ----------------------------------------------------------------------------
// lowest_set_bit_8 : combinational priority encoder, lowest set bit wins
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module lowest_set_bit_8
  import lm_pkg::*;
(
  input  logic [7:0] mask,
  output logic [2:0] index,
  output logic       valid
);

  // Scan downwards so the last hit (lowest index) takes priority.
  always_comb begin
    index = 3'd0;
    valid = 1'b0;
    for (int i = REG_CNT - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/load_multiple_sequencer.sv
// ----------------------------------------------------------------------------
// load_multiple_sequencer : LM/LA read sequencer feeding the register bank
// Option macro: LM_R7_WRITE_EN (R7 loadable through the PC write port)
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module load_multiple_sequencer
  import lm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              loadAll,
  input  logic [7:0]        regMask,
  input  logic [ADDR_W-1:0] baseAddr,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memReadEn,
  input  logic [DATA_W-1:0] memReadData,
  output logic [2:0]        writeAddress,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEnable,
  output logic [DATA_W-1:0] pcWriteData,
  output logic              pcWriteEnable,
  output logic              busy,
  output logic              done
);

  lm_state_e         state_q, state_d;
  logic [7:0]        pending_q, pending_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [2:0]        wr_idx_q, wr_idx_d;
  logic              wr_valid_q, wr_valid_d;
  logic              mem_read_en_q, mem_read_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [7:0]        eff_mask;
  logic [7:0]        pending_clr;
  logic [2:0]        lsb_idx;
  logic              lsb_valid;

  lowest_set_bit_8 u_lsb (
    .mask  (pending_q),
    .index (lsb_idx),
    .valid (lsb_valid)
  );

`ifdef LM_R7_WRITE_EN
  assign eff_mask = loadAll ? MASK_ALL : regMask;
`else
  // Bit 7 dropped here so no read slot or address is spent on R7.
  assign eff_mask = (loadAll ? MASK_NO_PC : regMask) & MASK_NO_PC;
`endif

  assign pending_clr = pending_q & ~(8'(8'b1 << lsb_idx));

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    cur_addr_d = cur_addr_q;
    wr_idx_d   = wr_idx_q;
    wr_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pending_d  = eff_mask;
          cur_addr_d = baseAddr;
          state_d    = (eff_mask == 8'h00) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (lsb_valid) begin
          wr_idx_d   = lsb_idx;
          wr_valid_d = 1'b1;
          pending_d  = pending_clr;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
        end
        if (pending_clr == 8'h00) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign mem_read_en_d = (state_d == ST_RUN);
  assign busy_d        = (state_d != ST_IDLE);
  assign done_d        = (state_d == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pending_q     <= 8'h00;
      cur_addr_q    <= '0;
      wr_idx_q      <= 3'd0;
      wr_valid_q    <= 1'b0;
      mem_read_en_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      cur_addr_q    <= cur_addr_d;
      wr_idx_q      <= wr_idx_d;
      wr_valid_q    <= wr_valid_d;
      mem_read_en_q <= mem_read_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign memAddr      = cur_addr_q;
  assign memReadEn    = mem_read_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign writeAddress = wr_idx_q;
  assign writeEnable  = wr_valid_q && (wr_idx_q != PC_IDX);
  assign writeData    = wr_valid_q ? memReadData : '0;
  assign pcWriteData  = memReadData;

`ifdef LM_R7_WRITE_EN
  assign pcWriteEnable = wr_valid_q && (wr_idx_q == PC_IDX);
`else
  assign pcWriteEnable = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_load_multiple_sequencer.sv
// ----------------------------------------------------------------------------
// tb_load_multiple_sequencer : directed scoreboard bench for the LM sequencer
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_load_multiple_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        loadAll = 1'b0;
  logic [7:0]  regMask = 8'h00;
  logic [15:0] baseAddr = 16'h0000;
  logic [15:0] memAddr;
  logic        memReadEn;
  logic [15:0] memReadData = 16'h0000;
  logic [2:0]  writeAddress;
  logic [15:0] writeData;
  logic        writeEnable;
  logic [15:0] pcWriteData;
  logic        pcWriteEnable;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic        pc;
    logic [2:0]  idx;
    logic [15:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [15:0] rq[$];
  logic [15:0] mem [0:255];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  load_multiple_sequencer #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .loadAll      (loadAll),
    .regMask      (regMask),
    .baseAddr     (baseAddr),
    .memAddr      (memAddr),
    .memReadEn    (memReadEn),
    .memReadData  (memReadData),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .writeEnable  (writeEnable),
    .pcWriteData  (pcWriteData),
    .pcWriteEnable(pcWriteEnable),
    .busy         (busy),
    .done         (done)
  );

  // Synchronous-read data memory: data is valid the cycle after the strobe.
  always @(posedge clk) begin
    memReadData <= memReadEn ? mem[memAddr[7:0]] : 16'h0000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected read/write whenever the DUT presents one.
  always @(negedge clk) begin
    wr_t         w;
    logic [15:0] a;
    check("we_exclusive", {31'b0, writeEnable & pcWriteEnable}, 32'd0);
    if (memReadEn) begin
      if (rq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_read: got addr %0h, required no read", memAddr);
      end else begin
        a = rq.pop_front();
        check("read_addr", {16'h0, memAddr}, {16'h0, a});
      end
    end
    if (writeEnable || pcWriteEnable) begin
      if (wq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got idx %0d pc %0d data %0h, required no write",
                 writeAddress, pcWriteEnable, pcWriteEnable ? pcWriteData : writeData);
      end else begin
        w = wq.pop_front();
        check("write_kind", {31'b0, pcWriteEnable}, {31'b0, w.pc});
        if (!w.pc) check("write_addr", {29'b0, writeAddress}, {29'b0, w.idx});
        check("write_data", {16'h0, pcWriteEnable ? pcWriteData : writeData}, {16'h0, w.data});
      end
    end
  end

  task automatic push_wr(input logic pc, input logic [2:0] idx, input logic [15:0] data);
    wr_t w;
    w.pc   = pc;
    w.idx  = idx;
    w.data = data;
    wq.push_back(w);
  endtask

  task automatic run_op(input string name, input logic la, input logic [7:0] mask,
                        input logic [15:0] base, input int exp_done, input int restart_at);
    int done_at = 0;
    @(negedge clk);
    start = 1'b1; loadAll = la; regMask = mask; baseAddr = base;
    @(posedge clk);
    #1 start = 1'b0; loadAll = 1'b0;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      @(negedge clk);
      check({name, "_busy"}, {31'b0, busy}, 32'd1);
      if (done) done_at = k;
      if (k == restart_at) begin
        start = 1'b1; regMask = 8'h01; baseAddr = 16'h0060;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({name, "_done_cycle"}, done_at, exp_done);
    @(negedge clk);
    check({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({name, "_idle_done"}, {31'b0, done}, 32'd0);
    check({name, "_writes_left"}, wq.size(), 32'd0);
    check({name, "_reads_left"}, rq.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[8'h40] = 16'hAAAA;
    mem[8'h41] = 16'hBBBB;
    for (int k = 0; k < 8; k++) mem[8'h10 + k] = 16'(k + 1);
    mem[8'hFF] = 16'hF0F0;
    mem[8'h00] = 16'h0F0F;
    mem[8'h50] = 16'h5050;
    mem[8'h51] = 16'h5151;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_memReadEn", {31'b0, memReadEn}, 32'd0);
    check("rst_writeEnable", {31'b0, writeEnable}, 32'd0);
    check("rst_pcWriteEnable", {31'b0, pcWriteEnable}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_memAddr", {16'h0, memAddr}, 32'd0);
    check("rst_writeAddress", {29'b0, writeAddress}, 32'd0);
    reset = 1'b0;

    // Sparse mask: R0 and R2 from consecutive words.
    rq.push_back(16'h0040); rq.push_back(16'h0041);
    push_wr(1'b0, 3'd0, 16'hAAAA);
    push_wr(1'b0, 3'd2, 16'hBBBB);
    run_op("lm_0101", 1'b0, 8'b0000_0101, 16'h0040, 4, 0);

    // Load all; regMask is ignored.
    for (int k = 0; k < 7; k++) begin
      rq.push_back(16'h0010 + 16'(k));
      push_wr(1'b0, 3'(k), 16'(k + 1));
    end
`ifdef LM_R7_WRITE_EN
    rq.push_back(16'h0017);
    push_wr(1'b1, 3'd7, 16'd8);
    run_op("load_all", 1'b1, 8'h01, 16'h0010, 10, 0);
`else
    run_op("load_all", 1'b1, 8'h01, 16'h0010, 9, 0);
`endif

    // Empty mask.
    run_op("empty", 1'b0, 8'h00, 16'h0070, 1, 0);

    // Address wrap.
    rq.push_back(16'hFFFF); rq.push_back(16'h0000);
    push_wr(1'b0, 3'd0, 16'hF0F0);
    push_wr(1'b0, 3'd1, 16'h0F0F);
    run_op("wrap", 1'b0, 8'b0000_0011, 16'hFFFF, 4, 0);

    // Reset in cycle 2 of a five-register load.
    rq.push_back(16'h0020); rq.push_back(16'h0021);
    push_wr(1'b0, 3'd0, mem[8'h20]);
    @(negedge clk);
    start = 1'b1; regMask = 8'h1F; baseAddr = 16'h0020;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_we", {31'b0, writeEnable}, 32'd0);
    check("rst_mid_pcwe", {31'b0, pcWriteEnable}, 32'd0);
    check("rst_mid_rd", {31'b0, memReadEn}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_done", {31'b0, done}, 32'd0);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("post_rst_writes_left", wq.size(), 32'd0);
    check("post_rst_reads_left", rq.size(), 32'd0);

    // Normal run after reset; bit 7 only honoured with the R7 option.
    rq.push_back(16'h0030);
    push_wr(1'b0, 3'd0, mem[8'h30]);
`ifdef LM_R7_WRITE_EN
    rq.push_back(16'h0031);
    push_wr(1'b1, 3'd7, mem[8'h31]);
    run_op("after_rst", 1'b0, 8'h81, 16'h0030, 4, 0);
`else
    run_op("after_rst", 1'b0, 8'h81, 16'h0030, 3, 0);
`endif

    // Second start while busy must be ignored.
    rq.push_back(16'h0050); rq.push_back(16'h0051);
    push_wr(1'b0, 3'd1, 16'h5050);
    push_wr(1'b0, 3'd6, 16'h5151);
    run_op("restart_busy", 1'b0, 8'b0100_0010, 16'h0050, 4, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
